// File: rtl/ulpi_reg_seq_if.sv
// Register-port bus between the ULPI init sequencer (master) and the ULPI wrapper (slave).
// One request at a time: stb/addr/we/data are held until ack, and read data is valid with ack.
interface ulpi_reg_seq_if;
  logic [7:0] reg_addr_o;
  logic       reg_stb_o;
  logic       reg_we_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic       reg_ack_i;

  modport master (
    output reg_addr_o,
    output reg_stb_o,
    output reg_we_o,
    output reg_data_o,
    input  reg_data_i,
    input  reg_ack_i
  );

  modport slave (
    input  reg_addr_o,
    input  reg_stb_o,
    input  reg_we_o,
    input  reg_data_o,
    output reg_data_i,
    output reg_ack_i
  );
endinterface

// File: rtl/ulpi_reg_seq.sv
// ULPI PHY bring-up sequencer: reads the vendor/product ID, programs Function Control and verifies
// it. Define ULPI_REG_SEQ_SCRATCH_EN to append a write/readback check of the Scratch register.
module ulpi_reg_seq #(
  parameter logic [7:0]  FUNC_CTRL_VAL = 8'h41,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  ulpi_reg_seq_if.master bus,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [1:0]     err_code_o,
  output logic [31:0]    phy_id_o,
  output logic [7:0]     func_ctrl_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWaitAck = 3'd2;
  localparam logic [2:0] StGap     = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StError   = 3'd5;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrFuncCtl = 2'd2;
`ifdef ULPI_REG_SEQ_SCRATCH_EN
  localparam logic [1:0] ErrScratch = 2'd3;
  localparam logic [7:0] ScratchVal = 8'h5A;
  localparam logic [7:0] ScratchReg = 8'h16;
  localparam logic [2:0] LastStep   = 3'd7;
`else
  localparam logic [2:0] LastStep   = 3'd5;
`endif

  localparam logic [7:0]  FuncCtlReg = 8'h04;
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYC);

  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] phy_id_q, phy_id_d;
  logic [7:0]  func_ctrl_q, func_ctrl_d;

  logic [7:0]  step_addr;
  logic        step_we;
  logic [7:0]  step_data;
  logic        ack_ok;

  // Fixed step table; read steps drive zero on the data bus.
  always_comb begin
    step_addr = 8'h00;
    step_we   = 1'b0;
    step_data = 8'h00;
    case (step_q)
      3'd0, 3'd1, 3'd2, 3'd3: step_addr = {6'd0, step_q[1:0]};
      3'd4: begin
        step_addr = FuncCtlReg;
        step_we   = 1'b1;
        step_data = FUNC_CTRL_VAL;
      end
      3'd5: step_addr = FuncCtlReg;
`ifdef ULPI_REG_SEQ_SCRATCH_EN
      3'd6: begin
        step_addr = ScratchReg;
        step_we   = 1'b1;
        step_data = ScratchVal;
      end
      3'd7: step_addr = ScratchReg;
`endif
      default: step_addr = 8'h00;
    endcase
  end

  // An ack only counts while a request is actually on the bus.
  assign ack_ok = (state_q == StWaitAck) && stb_q && bus.reg_ack_i;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_code_d  = err_code_q;
    phy_id_d    = phy_id_q;
    func_ctrl_d = func_ctrl_q;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d    = StIssue;
          step_d     = 3'd0;
          err_code_d = ErrNone;
        end
      end
      StIssue: begin
        addr_d  = step_addr;
        we_d    = step_we;
        wdata_d = step_data;
        stb_d   = 1'b1;
        cnt_d   = 16'd0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (ack_ok) begin
          stb_d = 1'b0;
          if (!we_q) begin
            if (step_q <= 3'd3) begin
              phy_id_d[{step_q[1:0], 3'b000} +: 8] = bus.reg_data_i;
            end else if (step_q == 3'd5) begin
              func_ctrl_d = bus.reg_data_i;
            end
          end
          if (step_q == 3'd5 && bus.reg_data_i != FUNC_CTRL_VAL) begin
            state_d    = StError;
            err_code_d = ErrFuncCtl;
          end
`ifdef ULPI_REG_SEQ_SCRATCH_EN
          else if (step_q == 3'd7 && bus.reg_data_i != ScratchVal) begin
            state_d    = StError;
            err_code_d = ErrScratch;
          end
`endif
          else if (step_q == LastStep) begin
            state_d = StDone;
          end else begin
            state_d = StGap;
          end
        end else if (cnt_q == TimeoutCnt) begin
          stb_d      = 1'b0;
          state_d    = StError;
          err_code_d = ErrTimeout;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGap: begin
        step_d  = step_q + 3'd1;
        state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      step_q      <= 3'd0;
      cnt_q       <= 16'd0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      err_code_q  <= ErrNone;
      phy_id_q    <= 32'h0;
      func_ctrl_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_code_q  <= err_code_d;
      phy_id_q    <= phy_id_d;
      func_ctrl_q <= func_ctrl_d;
    end
  end

  assign bus.reg_addr_o = addr_q;
  assign bus.reg_stb_o  = stb_q;
  assign bus.reg_we_o   = we_q;
  assign bus.reg_data_o = wdata_q;

  assign busy_o      = (state_q == StIssue) || (state_q == StWaitAck) || (state_q == StGap);
  assign done_o      = (state_q == StDone);
  assign err_o       = (state_q == StError);
  assign err_code_o  = err_code_q;
  assign phy_id_o    = phy_id_q;
  assign func_ctrl_o = func_ctrl_q;

endmodule

// File: tb/tb_ulpi_reg_seq.sv
// Scoreboard bench for ulpi_reg_seq: a step-list reference model queues expected transactions
// and run outcomes; a negedge monitor checks them against the bus and status outputs.
module tb_ulpi_reg_seq;

  localparam logic [7:0] FcVal = 8'h41;
  localparam int         Tmo   = 255;
`ifdef ULPI_REG_SEQ_SCRATCH_EN
  localparam int NSteps = 8;
`else
  localparam int NSteps = 6;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
    int         len;   // expected stb-high cycles, 0 = not checked
  } txn_t;

  typedef struct {
    int          ntx;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [31:0] phy;
    logic [7:0]  fc;
  } end_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] phy_id;
  logic [7:0]  func_ctrl;

  ulpi_reg_seq_if bus ();

  ulpi_reg_seq #(
    .FUNC_CTRL_VAL(FcVal),
    .TIMEOUT_CYC  (Tmo)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code),
    .phy_id_o   (phy_id),
    .func_ctrl_o(func_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  txn_t exp_txn[$];
  end_t exp_end[$];
  int   dly_q[$];

  logic [7:0]  rd_val [0:255];
  int          dly [0:7];
  logic [31:0] m_phy;
  logic [7:0]  m_fc;

  int checks = 0;
  int errors = 0;
  int idle_req = 0;
  int idle_done = 0;
  int spur_req = 0;
  int spur_done = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: walk the step list, stop at the first timeout or readback mismatch.
  task automatic plan_run();
    end_t       e;
    txn_t       t;
    logic [7:0] rd;
    int         n = 0;
    e.done = 1'b0;
    e.err  = 1'b0;
    e.code = 2'd0;
    for (int i = 0; i < NSteps; i++) begin
      t.addr = (i < 4) ? 8'(i) : (i < 6) ? 8'h04 : 8'h16;
      t.we   = (i == 4) || (i == 6);
      t.data = (i == 4) ? FcVal : 8'h5A;
      rd     = rd_val[t.addr];
      n++;
      dly_q.push_back(dly[i]);
      if (dly[i] < 0 || dly[i] > Tmo) begin
        t.len = Tmo + 1;
        exp_txn.push_back(t);
        e.err  = 1'b1;
        e.code = 2'd1;
        break;
      end
      t.len = dly[i] + 1;
      exp_txn.push_back(t);
      if (i < 4) m_phy[8*i +: 8] = rd;
      if (i == 5) m_fc = rd;
      if (i == 5 && rd != FcVal) begin
        e.err  = 1'b1;
        e.code = 2'd2;
        break;
      end
      if (i == 7 && rd != 8'h5A) begin
        e.err  = 1'b1;
        e.code = 2'd3;
        break;
      end
    end
    e.done = !e.err;
    e.ntx  = n;
    e.phy  = m_phy;
    e.fc   = m_fc;
    exp_end.push_back(e);
  endtask

  // Wrapper model: acks each request after its planned delay, plus stray acks while idle.
  int w_cnt = 0;
  int w_dly = 0;
  bit w_active = 0;
  always @(negedge clk) begin
    if (bus.reg_stb_o === 1'b1) begin
      if (!w_active) begin
        w_active = 1;
        w_cnt    = 0;
        w_dly    = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
      end else begin
        w_cnt++;
      end
      if (w_dly >= 0 && w_cnt == w_dly) begin
        bus.reg_ack_i  = 1'b1;
        bus.reg_data_i = bus.reg_we_o ? 8'($urandom) : rd_val[bus.reg_addr_o];
      end else begin
        bus.reg_ack_i  = 1'b0;
        bus.reg_data_i = 8'($urandom);
      end
    end else begin
      w_active = 0;
      if (spur_req != spur_done) begin
        spur_done++;
        bus.reg_ack_i = 1'b1;
      end else begin
        bus.reg_ack_i = ($urandom_range(0, 4) == 0);
      end
      bus.reg_data_i = 8'($urandom);
    end
  end

  // Monitor / scoreboard.
  logic       prev_stb = 0;
  logic       prev_busy = 0;
  int         low_cnt = 100;
  int         run_tx = 0;
  int         len = 0;
  int         wd = 0;
  bit         have_cur = 0;
  bit         stable = 1;
  txn_t       cur;
  end_t       e;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_we;

  always @(negedge clk) begin
    if (bus.reg_stb_o && !prev_stb) begin
      if (low_cnt < 10) chk("stb_gap", low_cnt, 2);
      low_cnt = 0;
      run_tx++;
      len    = 1;
      stable = 1;
      s_addr = bus.reg_addr_o;
      s_we   = bus.reg_we_o;
      s_data = bus.reg_data_o;
      if (exp_txn.size() == 0) begin
        errors++;
        have_cur = 0;
        $display("FAIL extra_txn: got addr %0h expected none", bus.reg_addr_o);
      end else begin
        cur      = exp_txn.pop_front();
        have_cur = 1;
        chk("txn_addr", bus.reg_addr_o, cur.addr);
        chk("txn_we", bus.reg_we_o, cur.we);
        if (cur.we) chk("txn_wdata", bus.reg_data_o, cur.data);
      end
    end else if (bus.reg_stb_o) begin
      len++;
      if (bus.reg_addr_o != s_addr || bus.reg_we_o != s_we || bus.reg_data_o != s_data) stable = 0;
    end else if (prev_stb) begin
      chk("txn_stable", stable, 1);
      if (have_cur && cur.len != 0) chk("stb_len", len, cur.len);
      have_cur = 0;
    end
    if (!bus.reg_stb_o && low_cnt < 100) low_cnt++;

    if (prev_busy && !busy) begin
      wd = 0;
      if (exp_end.size() == 0) begin
        errors++;
        $display("FAIL extra_end: got busy fall expected none");
      end else begin
        e = exp_end.pop_front();
        chk("end_ntx", run_tx, e.ntx);
        chk("end_done", done, e.done);
        chk("end_err", err, e.err);
        chk("end_code", err_code, e.code);
        chk("end_phy_id", phy_id, e.phy);
        chk("end_func_ctrl", func_ctrl, e.fc);
        chk("end_stb_low", bus.reg_stb_o, 0);
        chk("end_exclusive", done & err, 0);
      end
      run_tx = 0;
    end

    if (idle_req != idle_done) begin
      idle_done++;
      chk("idle_busy", busy, 0);
      chk("idle_stb", bus.reg_stb_o, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
      chk("idle_code", err_code, 0);
      chk("idle_addr", bus.reg_addr_o, 0);
      chk("idle_we", bus.reg_we_o, 0);
      chk("idle_wdata", bus.reg_data_o, 0);
      chk("idle_phy_id", phy_id, m_phy);
      chk("idle_func_ctrl", func_ctrl, m_fc);
    end

    if (exp_end.size() != 0) wd++;
    else wd = 0;
    if (wd > 5000) begin
      errors++;
      $display("FAIL watchdog: got no end after %0d cycles expected run end", wd);
      exp_end.delete();
      exp_txn.delete();
      dly_q.delete();
      wd = 0;
    end

    prev_stb  = bus.reg_stb_o;
    prev_busy = busy;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_nominal();
    rd_val[8'h00] = 8'h24;
    rd_val[8'h01] = 8'h04;
    rd_val[8'h02] = 8'h04;
    rd_val[8'h03] = 8'h00;
    rd_val[8'h04] = FcVal;
    rd_val[8'h16] = 8'h5A;
    for (int i = 0; i < 8; i++) dly[i] = 3;
  endtask

  task automatic run_one();
    plan_run();
    cyc(12);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    while (exp_end.size() != 0) cyc(1);
  endtask

  txn_t rt;
  end_t re;

  initial begin
    for (int i = 0; i < 256; i++) rd_val[i] = 8'(i);
    bus.reg_ack_i  = 1'b0;
    bus.reg_data_i = 8'h00;
    rst   = 1'b1;
    start = 1'b1;
    m_phy = 32'h0;
    m_fc  = 8'h00;
    cyc(4);
    rst   = 1'b0;
    start = 1'b0;
    idle_req++;
    cyc(2);

    // Nominal bring-up, then Function Control and scratch readback mismatches.
    set_nominal();
    run_one();
    rd_val[8'h04] = 8'h40;
    run_one();
    rd_val[8'h04] = FcVal;
    rd_val[8'h16] = 8'hA5;
    run_one();
    set_nominal();

    // Ack timeout and its exact boundary.
    dly[0] = -1;
    run_one();
    dly[0] = Tmo;
    run_one();
    dly[0] = Tmo + 1;
    run_one();
    set_nominal();
    dly[3] = -1;
    run_one();

    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 4; a++) rd_val[a] = 8'($urandom);
      rd_val[8'h04] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : FcVal;
      rd_val[8'h16] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h5A;
      for (int i = 0; i < 8; i++) dly[i] = ($urandom_range(0, 14) == 0) ? -1 : $urandom_range(0, 6);
      run_one();
    end

    // start held high: back-to-back runs.
    set_nominal();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) dly[i] = $urandom_range(0, 5);
      plan_run();
    end
    cyc(12);
    start = 1'b1;
    while (exp_end.size() != 0) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;

    // Reset during WAIT_ACK of S2, then a stray ack.
    for (int a = 0; a < 4; a++) rd_val[a] = 8'($urandom);
    dly[0] = 1;
    dly[1] = 2;
    dly[2] = 20;
    for (int i = 0; i < 3; i++) begin
      rt.addr = 8'(i);
      rt.we   = 1'b0;
      rt.data = 8'h00;
      rt.len  = (i < 2) ? dly[i] + 1 : 0;
      exp_txn.push_back(rt);
      dly_q.push_back(dly[i]);
    end
    re.ntx  = 3;
    re.done = 1'b0;
    re.err  = 1'b0;
    re.code = 2'd0;
    re.phy  = 32'h0;
    re.fc   = 8'h00;
    exp_end.push_back(re);
    cyc(12);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (bus.reg_stb_o && bus.reg_addr_o == 8'h02) break;
      cyc(1);
    end
    cyc(2);
    rst   = 1'b1;
    m_phy = 32'h0;
    m_fc  = 8'h00;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    spur_req++;
    cyc(6);
    idle_req++;
    cyc(4);
    while (exp_end.size() != 0) cyc(1);

    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_seq.md
ULPI_REG_SEQ -- requirements
Module: ulpi_reg_seq

Interface
REQ-001 Parameter FUNC_CTRL_VAL, default 8'h41, value written to the PHY Function Control register (SuspendM=1, XcvrSelect=01, TermSelect=0, OpMode=00, Reset=0).
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum number of cycles a transaction waits for reg_ack_i; legal range 1..65535.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  ULPI 60 MHz clock, same clock as the wrapper register port.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  level; starts a sequence when sampled high while not busy.
REQ-007 reg_addr_o  output  8  ULPI register address to wrapper.
REQ-008 reg_stb_o  output  1  transaction request to wrapper.
REQ-009 reg_we_o  output  1  1=write, 0=read.
REQ-010 reg_data_o  output  8  write data.
REQ-011 reg_data_i  input  8  read data, valid when reg_ack_i=1.
REQ-012 reg_ack_i  input  1  transaction complete.
REQ-013 busy_o  output  1  sequence in progress.
REQ-014 done_o  output  1  sequence completed without error; held until next start or reset.
REQ-015 err_o  output  1  sequence aborted; held until next start or reset.
REQ-016 err_code_o  output  2  0=none, 1=ack timeout, 2=Function Control readback mismatch, 3=scratch mismatch.
REQ-017 phy_id_o  output  32  {PID_hi, PID_lo, VID_hi, VID_lo} captured from registers 0x03..0x00.
REQ-018 func_ctrl_o  output  8  last value read back from register 0x04.

Function
REQ-019 States: IDLE, ISSUE, WAIT_ACK, GAP, DONE, ERROR; step index selects the entry of a fixed step table.
REQ-020 Step table: S0 read 0x00, S1 read 0x01, S2 read 0x02, S3 read 0x03, S4 write 0x04 with FUNC_CTRL_VAL, S5 read 0x04, then the optional scratch steps (REQ-036), then DONE.
REQ-021 IDLE/DONE/ERROR with start_i=1: clear done_o, err_o, and err_code_o; step=0; go to ISSUE; reg_stb_o rises on the next cycle (1-cycle start latency).
REQ-022 ISSUE: drive reg_addr_o, reg_we_o, and reg_data_o from the step table; reg_stb_o=1; clear the timeout counter; go to WAIT_ACK.
REQ-023 WAIT_ACK: reg_stb_o, address, data, and we held stable until the cycle reg_ack_i=1 is sampled; reg_stb_o=0 on the following cycle.
REQ-024 On ack of a read: capture reg_data_i in the same cycle into the phy_id_o byte for S0..S3, or into func_ctrl_o for S5.
REQ-025 S5 compare: if the readback is not equal to FUNC_CTRL_VAL, go to ERROR with err_code_o=2.
REQ-026 After a good ack, go to GAP for exactly one cycle with reg_stb_o=0, then ISSUE the next step; only one transaction is outstanding at a time.
REQ-027 Timeout: the counter increments every WAIT_ACK cycle without ack; when it equals TIMEOUT_CYC, reg_stb_o=0 next cycle and go to ERROR with err_code_o=1.
REQ-028 An ack on the same cycle the counter reaches TIMEOUT_CYC SHALL count as success.
REQ-029 reg_ack_i while reg_stb_o=0 is ignored, with no capture and no state change.
REQ-030 start_i while busy_o=1 is ignored.
REQ-031 busy_o=1 exactly in ISSUE, WAIT_ACK, and GAP.
REQ-032 In DONE, done_o=1; in ERROR, err_o=1. Both hold until the next start or reset. done_o and err_o are never both 1.

Reset
REQ-033 rst_i=1 on a clock edge sets state IDLE and step 0. Reset values: reg_stb_o=0, reg_we_o=0, reg_addr_o=0, reg_data_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0, phy_id_o=0, func_ctrl_o=0.
REQ-034 Reset mid-transaction drops reg_stb_o on the following cycle; any later ack is ignored per REQ-029.
REQ-035 Reset has priority over start_i and reg_ack_i in the same cycle.

Configuration
REQ-036 Macro ULPI_REG_SEQ_SCRATCH_EN defined: append S6 write 0x16 with 8'h5A and S7 read 0x16; a mismatch against 8'h5A goes to ERROR with err_code_o=3.
REQ-037 Macro ULPI_REG_SEQ_SCRATCH_EN undefined: the sequence ends after S5, and err_code_o never takes the value 3.

Verification
REQ-038 Scenario: wrapper model acks after 3 cycles and returns 0x24,0x04,0x04,0x00 for 0x00..0x03 and 0x41 for 0x04 -> phy_id_o=32'h0004_0424, func_ctrl_o=8'h41, done_o=1, err_code_o=0; 6 transactions without the macro, 8 with it.
REQ-039 Scenario: no ack on S0 with TIMEOUT_CYC=255 -> reg_stb_o high for 256 cycles, then err_o=1 and err_code_o=1, busy_o=0.
REQ-040 Scenario: readback of 0x04 returns 0x40 -> err_o=1, err_code_o=2, func_ctrl_o=8'h40, and no scratch steps issued.
REQ-041 Scenario: macro defined, scratch read returns 0xA5 -> err_code_o=3; macro undefined -> no access to 0x16.
REQ-042 Scenario: rst_i pulsed during WAIT_ACK of S2, with a spurious ack 2 cycles later -> all outputs equal reset values, and phy_id_o stays 0.
REQ-043 Scenario: start_i held high throughout -> the sequence re-runs immediately after DONE; stb gaps are at least 1 cycle and stb stays stable until ack.
